// File: rtl/cdc_handshake_tx.sv
// Source side of a four-phase req/ack crossing: latches a word, raises a level
// request, and waits for the re-synchronised acknowledge to rise and then fall.
module cdc_handshake_tx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic                  InValid,
  output logic                  InReady,
  output logic [DATA_WIDTH-1:0] TxData,
  output logic                  TxReq,
  input  logic                  TxAck,
  output logic                  Done
);

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    ACK_WAIT_LO
  } state_t;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("cdc_handshake_tx: SYNC_STAGES must be 2..4");
    end
  endgenerate

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    req_q, req_d;
  logic                    done_q, done_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    ack_s;
  logic                    accept;

  // Acknowledge is asynchronous to CLK; only the last stage is ever looked at.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) sync_q[gi] <= 1'b0;
          else      sync_q[gi] <= TxAck;
        end
      end else begin : g_rest
        always_ff @(posedge CLK or negedge RST) begin
          if (!RST) sync_q[gi] <= 1'b0;
          else      sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign ack_s   = sync_q[SYNC_STAGES-1];
  assign InReady = (state_q == IDLE) && !ack_s;
  assign accept  = InValid && InReady;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = InData;
          req_d   = 1'b1;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = ACK_WAIT_LO;
        end
      end
      ACK_WAIT_LO: begin
        // Completion only once the destination has released its acknowledge.
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign TxData = data_q;
  assign TxReq  = req_q;
  assign Done   = done_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Bench for cdc_handshake_tx: an 8-bit/2-stage and a 16-bit/3-stage instance,
// with a word scoreboard popped on every Done pulse.
module tb_cdc_handshake_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  in_data_a, tx_data_a;
  logic        in_valid_a, in_ready_a, tx_req_a, tx_ack_a, done_a;
  logic        tx_ack_man_a, echo_en;
  logic [1:0]  echo_pipe = 2'b00;
  logic [15:0] in_data_b, tx_data_b;
  logic        in_valid_b, in_ready_b, tx_req_b, tx_ack_b, done_b;

  int checks = 0, passed = 0;
  int done_cnt_a = 0, done_cnt_b = 0, cyc = 0, done_cyc_b = 0;
  logic done_prev_a = 1'b0, done_prev_b = 1'b0;
  logic [7:0]  sb_a[$];
  logic [15:0] sb_b[$];

  cdc_handshake_tx #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut_a (
    .CLK(clk), .RST(rst_n), .InData(in_data_a), .InValid(in_valid_a),
    .InReady(in_ready_a), .TxData(tx_data_a), .TxReq(tx_req_a),
    .TxAck(tx_ack_a), .Done(done_a)
  );

  cdc_handshake_tx #(.DATA_WIDTH(16), .SYNC_STAGES(3)) dut_b (
    .CLK(clk), .RST(rst_n), .InData(in_data_b), .InValid(in_valid_b),
    .InReady(in_ready_b), .TxData(tx_data_b), .TxReq(tx_req_b),
    .TxAck(tx_ack_b), .Done(done_b)
  );

  // Model destination: echoes TxReq back as TxAck two cycles later.
  always @(posedge clk) echo_pipe <= {echo_pipe[0], tx_req_a};
  assign tx_ack_a = echo_en ? echo_pipe[1] : tx_ack_man_a;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done_a) begin
        done_cnt_a = done_cnt_a + 1;
        checks = checks + 1;
        if (sb_a.size() == 0) $display("FAIL sb_a_unexpected_done: actual TxData=%h, required no Done", tx_data_a);
        else begin
          logic [7:0] exp_a;
          exp_a = sb_a.pop_front();
          if (tx_data_a !== exp_a) $display("FAIL sb_a_data: actual %h, required %h", tx_data_a, exp_a);
          else begin passed = passed + 1; $display("xfer A done data=%h", tx_data_a); end
        end
        checks = checks + 1;
        if (done_prev_a) $display("FAIL done_a_width: actual 2+ cycles, required 1");
        else passed = passed + 1;
      end
      if (done_b) begin
        done_cnt_b = done_cnt_b + 1;
        done_cyc_b = cyc;
        checks = checks + 1;
        if (sb_b.size() == 0) $display("FAIL sb_b_unexpected_done: actual TxData=%h, required no Done", tx_data_b);
        else begin
          logic [15:0] exp_b;
          exp_b = sb_b.pop_front();
          if (tx_data_b !== exp_b) $display("FAIL sb_b_data: actual %h, required %h", tx_data_b, exp_b);
          else begin passed = passed + 1; $display("xfer B done data=%h", tx_data_b); end
        end
      end
    end
    done_prev_a = done_a;
    done_prev_b = done_b;
  end

  task automatic test_reset();
    checks += 4;
    if (in_ready_a !== 1'b1) $display("FAIL reset_inready: actual %b, required 1", in_ready_a); else passed++;
    if (tx_req_a !== 1'b0)   $display("FAIL reset_txreq: actual %b, required 0", tx_req_a); else passed++;
    if (done_a !== 1'b0)     $display("FAIL reset_done: actual %b, required 0", done_a); else passed++;
    if (tx_data_a !== 8'h00) $display("FAIL reset_txdata: actual %h, required 00", tx_data_a); else passed++;
  endtask

  // One full manual handshake on instance A; with busy set, a foreign word is
  // offered throughout REQ_HI and must be ignored.
  task automatic xfer_a(input logic [7:0] w, input bit busy);
    int d0;
    d0 = done_cnt_a;
    @(negedge clk);
    checks++; if (in_ready_a !== 1'b1) $display("FAIL xfer_ready: actual %b, required 1", in_ready_a); else passed++;
    in_data_a = w; in_valid_a = 1'b1; sb_a.push_back(w);
    @(posedge clk); #1;
    if (busy) in_data_a = 8'h3C; else in_valid_a = 1'b0;
    checks += 3;
    if (tx_req_a !== 1'b1)   $display("FAIL accept_req: actual %b, required 1", tx_req_a); else passed++;
    if (tx_data_a !== w)     $display("FAIL accept_data: actual %h, required %h", tx_data_a, w); else passed++;
    if (in_ready_a !== 1'b0) $display("FAIL accept_ready: actual %b, required 0", in_ready_a); else passed++;
    repeat (3) begin
      @(posedge clk); #1;
      checks += 2;
      if (tx_data_a !== w || tx_req_a !== 1'b1) $display("FAIL reqhi_hold: actual data=%h req=%b, required %h/1", tx_data_a, tx_req_a, w); else passed++;
      if (in_ready_a !== 1'b0) $display("FAIL reqhi_ready: actual %b, required 0", in_ready_a); else passed++;
    end
    tx_ack_man_a = 1'b1;
    @(posedge clk); #1;  // edge j: first sample of TxAck=1
    @(posedge clk); #1;  // j+1
    checks++; if (tx_req_a !== 1'b1) $display("FAIL req_fall_early: actual %b at j+1, required 1", tx_req_a); else passed++;
    @(posedge clk); #1;  // j+2
    checks += 2;
    if (tx_req_a !== 1'b0) $display("FAIL req_fall: actual %b at j+2, required 0", tx_req_a); else passed++;
    if (tx_data_a !== w)   $display("FAIL ackwait_data: actual %h, required %h", tx_data_a, w); else passed++;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if (tx_data_a !== w || in_ready_a !== 1'b0 || done_a !== 1'b0)
        $display("FAIL ackwait_hold: actual data=%h ready=%b done=%b, required %h/0/0", tx_data_a, in_ready_a, done_a, w);
      else passed++;
    end
    tx_ack_man_a = 1'b0;
    @(posedge clk); #1;  // edge m
    @(posedge clk); #1;  // m+1
    in_valid_a = 1'b0;
    checks++; if (done_a !== 1'b0 || in_ready_a !== 1'b0) $display("FAIL done_early: actual done=%b ready=%b, required 0/0", done_a, in_ready_a); else passed++;
    @(posedge clk); #1;  // m+2
    checks += 2;
    if (done_a !== 1'b1)     $display("FAIL done_pulse: actual %b at m+2, required 1", done_a); else passed++;
    if (in_ready_a !== 1'b1) $display("FAIL done_ready: actual %b, required 1", in_ready_a); else passed++;
    @(posedge clk); #1;  // m+3
    checks += 3;
    if (done_a !== 1'b0)         $display("FAIL done_clear: actual %b, required 0", done_a); else passed++;
    if (done_cnt_a - d0 != 1)    $display("FAIL done_count: actual %0d, required 1", done_cnt_a - d0); else passed++;
    if (tx_data_a !== w)         $display("FAIL data_retained: actual %h, required %h", tx_data_a, w); else passed++;
  endtask

  task automatic test_single();
    xfer_a(8'hA5, 1'b0);
  endtask

  task automatic test_busy_reject();
    xfer_a(8'hA5, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] words [3];
    int d0, budget;
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    d0 = done_cnt_a;
    echo_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_data_a = words[i]; in_valid_a = 1'b1; sb_a.push_back(words[i]);
      budget = 0;
      while (in_ready_a !== 1'b1 && budget < 60) begin @(negedge clk); budget++; end
      checks++;
      if (budget >= 60) begin $display("FAIL b2b_timeout: actual no accept, required accept of %h", words[i]); break; end
      else passed++;
      if (i > 0) begin
        checks++; if (done_a !== 1'b1) $display("FAIL b2b_same_cycle: actual done=%b at accept, required 1", done_a); else passed++;
      end
      @(posedge clk); #1;
      checks++;
      if (tx_data_a !== words[i] || tx_req_a !== 1'b1) $display("FAIL b2b_accept: actual %h/%b, required %h/1", tx_data_a, tx_req_a, words[i]); else passed++;
    end
    in_valid_a = 1'b0;
    budget = 0;
    while (done_cnt_a - d0 < 3 && budget < 100) begin @(posedge clk); budget++; end
    #1;
    checks++; if (done_cnt_a - d0 != 3) $display("FAIL b2b_done_count: actual %0d, required 3", done_cnt_a - d0); else passed++;
    repeat (4) @(posedge clk);
    #1;
    echo_en = 1'b0;
  endtask

  task automatic test_stale_ack();
    int d0;
    d0 = done_cnt_a;
    tx_ack_man_a = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_data_a = 8'h77; in_valid_a = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready_a !== 1'b0 || tx_req_a !== 1'b0 || done_a !== 1'b0)
        $display("FAIL stale_block: actual ready=%b req=%b done=%b, required 0/0/0", in_ready_a, tx_req_a, done_a);
      else passed++;
    end
    in_valid_a = 1'b0;
    tx_ack_man_a = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready_a !== 1'b0) $display("FAIL stale_release_early: actual %b, required 0", in_ready_a); else passed++;
    @(posedge clk); #1;
    checks += 3;
    if (in_ready_a !== 1'b1)  $display("FAIL stale_release: actual %b, required 1", in_ready_a); else passed++;
    if (done_cnt_a != d0)     $display("FAIL stale_no_done: actual %0d pulses, required 0", done_cnt_a - d0); else passed++;
    if (tx_data_a !== 8'h00)  $display("FAIL stale_data: actual %h, required 00", tx_data_a); else passed++;
  endtask

  task automatic test_reset_mid();
    int budget;
    @(negedge clk);
    in_data_a = 8'h5A; in_valid_a = 1'b1;
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    tx_ack_man_a = 1'b1;
    budget = 0;
    while (tx_req_a !== 1'b0 && budget < 20) begin @(posedge clk); #1; budget++; end
    checks += 2;
    if (budget >= 20) $display("FAIL rstmid_timeout: actual TxReq stuck %b, required 0", tx_req_a); else passed++;
    if (tx_data_a !== 8'h5A) $display("FAIL rstmid_pre_data: actual %h, required 5A", tx_data_a); else passed++;
    #2; rst_n = 1'b0;
    #1;
    checks += 3;
    if (tx_data_a !== 8'h00) $display("FAIL rstmid_data: actual %h, required 00", tx_data_a); else passed++;
    if (tx_req_a !== 1'b0)   $display("FAIL rstmid_req: actual %b, required 0", tx_req_a); else passed++;
    if (done_a !== 1'b0)     $display("FAIL rstmid_done: actual %b, required 0", done_a); else passed++;
    tx_ack_man_a = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready_a !== 1'b1) $display("FAIL rstmid_ready: actual %b, required 1", in_ready_a); else passed++;
  endtask

  task automatic test_wide();
    int cyc_m;
    @(negedge clk);
    in_data_b = 16'hBEEF; in_valid_b = 1'b1; sb_b.push_back(16'hBEEF);
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    checks++; if (tx_data_b !== 16'hBEEF || tx_req_b !== 1'b1) $display("FAIL wide_accept: actual %h/%b, required BEEF/1", tx_data_b, tx_req_b); else passed++;
    repeat (2) @(posedge clk);
    #1; tx_ack_b = 1'b1;
    @(posedge clk); #1;  // j
    repeat (2) @(posedge clk);
    #1;                  // j+2
    checks++; if (tx_req_b !== 1'b1) $display("FAIL wide_req_early: actual %b at j+2, required 1", tx_req_b); else passed++;
    @(posedge clk); #1;  // j+3
    checks++; if (tx_req_b !== 1'b0) $display("FAIL wide_req_fall: actual %b at j+3, required 0", tx_req_b); else passed++;
    repeat (2) @(posedge clk);
    #1; tx_ack_b = 1'b0;
    @(posedge clk); #1;  // m
    cyc_m = cyc;
    repeat (2) @(posedge clk);
    #1;                  // m+2
    checks++; if (done_b !== 1'b0) $display("FAIL wide_done_early: actual %b at m+2, required 0", done_b); else passed++;
    @(posedge clk); #1;  // m+3
    checks += 2;
    if (done_b !== 1'b1)            $display("FAIL wide_done: actual %b at m+3, required 1", done_b); else passed++;
    if (tx_data_b !== 16'hBEEF)     $display("FAIL wide_data: actual %h, required BEEF", tx_data_b); else passed++;
    @(posedge clk); #1;
    checks += 3;
    if (done_b !== 1'b0)            $display("FAIL wide_done_clear: actual %b, required 0", done_b); else passed++;
    if (done_cyc_b != cyc_m + 3)    $display("FAIL wide_done_cycle: actual %0d, required %0d", done_cyc_b, cyc_m + 3); else passed++;
    if (done_cnt_b != 1)            $display("FAIL wide_done_count: actual %0d, required 1", done_cnt_b); else passed++;
  endtask

  initial begin
    rst_n = 1'b0;
    in_data_a = '0; in_valid_a = 1'b0; tx_ack_man_a = 1'b0; echo_en = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0; tx_ack_b = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_busy_reject();
    test_back_to_back();
    test_wide();
    test_stale_ack();
    test_reset_mid();
    repeat (2) @(posedge clk);
    #1;
    checks += 2;
    if (sb_a.size() != 0) $display("FAIL sb_a_leftover: actual %0d words, required 0", sb_a.size()); else passed++;
    if (sb_b.size() != 0) $display("FAIL sb_b_leftover: actual %0d words, required 0", sb_b.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual run still active, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side transmitter of the four-phase req/ack bus crossing. It captures a multi-bit word in the source clock domain, drives a level request and holds the word stable across the crossing. It waits for the destination's acknowledge to rise and fall, re-synchronising that acknowledge internally, then reports completion. It pairs with the destination-side bit synchronizer and data-capture logic and sits at every register or data bus hand-off between clock domains.

## Interface
- DATA_WIDTH, 8, width of the transferred word
- SYNC_STAGES, 2, flop stages on the incoming acknowledge (legal values 2 to 4)

- CLK  input  1  source-domain clock
- RST  input  1  asynchronous, active-low reset
- InData  input  DATA_WIDTH  word to send; sampled only on accept
- InValid  input  1  word-available request from the source logic
- InReady  output  1  combinational; high when a word can be accepted
- TxData  output  DATA_WIDTH  registered bus to the destination domain; stable while a transfer is in flight
- TxReq  output  1  registered level request to the destination domain
- TxAck  input  1  acknowledge from the destination domain; asynchronous to CLK
- Done  output  1  registered one-cycle pulse when a transfer completes

## Operation
- TxAck passes through a SYNC_STAGES flop chain to produce ack_s. The chain is cleared by reset and has no enable.
- The FSM has three states: IDLE, REQ_HI, ACK_WAIT_LO.
- InReady = (state == IDLE) && !ack_s.
- Accept: a rising edge with InValid && InReady. On accept:
  - TxData <= InData
  - TxReq <= 1
  - state moves to REQ_HI
- In REQ_HI:
  - ack_s == 1 -> TxReq <= 0, state moves to ACK_WAIT_LO.
  - Otherwise the block holds. There is no timeout.
- In ACK_WAIT_LO:
  - ack_s == 0 -> Done <= 1 for one cycle, state moves to IDLE.
  - Otherwise the block holds.
- TxData changes only on accept. It retains the last word after completion and is never cleared except by reset.
- InValid outside IDLE is ignored. InData is not sampled and TxData is not disturbed.
- If ack_s is high while in IDLE (stale or violating acknowledge), accept is blocked until ack_s falls. No Done pulse is generated for it.
- Done and a new accept may occur in the same cycle. This sustains back-to-back transfers.
- Reset is asynchronous and legal mid-transfer. It forces:
  - state = IDLE
  - TxReq = 0, Done = 0, TxData = 0
  - all sync flops = 0
  - InReady therefore reads 1 once reset is released.

## Timing
- Accept at edge k -> TxReq and TxData are valid after edge k. InReady is low from edge k.
- TxAck rises between edges j-1 and j -> ack_s is high after edge j+SYNC_STAGES-1 -> TxReq falls after edge j+SYNC_STAGES.
- TxAck falls between edges m-1 and m -> ack_s is low after edge m+SYNC_STAGES-1 -> Done is high and state is IDLE after edge m+SYNC_STAGES. Done is high for exactly one cycle.
- With a destination that acknowledges instantly, the minimum round trip is 2*SYNC_STAGES+2 source cycles per word.
- Requirements on TxData (no combinational path exists from TxAck to any output):
  - glitch-free while TxReq is high
  - unchanged until ack_s has been seen low

## Test plan
- Single transfer, SYNC_STAGES=2: accept InData=0xA5; raise TxAck 3 cycles after TxReq; drop it 3 cycles after TxReq falls. Required response:
  - TxData=0xA5 throughout
  - TxReq falls exactly 2 edges after the first edge sampling TxAck=1
  - one Done pulse
  - InReady low from accept until Done.
- Busy rejection: during REQ_HI drive InValid=1, InData=0x3C. TxData stays 0xA5, no extra transfer occurs, and Done count = 1.
- Back-to-back: hold InValid=1 with words 0x01, 0x02, 0x03 and a model destination echoing TxReq as TxAck after 2 cycles. Required: three transfers in order, three Done pulses, and each second word accepted on its own Done cycle.
- Stale acknowledge: hold TxAck=1 out of reset. Required: InReady=0, TxReq=0, no Done; after TxAck drops, InReady=1 after 2 edges.
- Reset mid-operation: assert RST in ACK_WAIT_LO with TxData=0x5A. Required, immediately and asynchronously: TxData=0, TxReq=0, Done=0; after release and TxAck=0, InReady=1.
- SYNC_STAGES=3, DATA_WIDTH=16: transfer 0xBEEF. Required: TxReq low-going edge lags the first sampled TxAck by 3 edges, and Done arrives at the computed cycle.
